// File: rtl/pen_cmd_dispatcher_if.sv
// rtl/pen_cmd_dispatcher_if.sv - servo position package and ServoCtrl trigger/rdy interface
package Servo_PKG;
   typedef enum logic {
      SERVO_POS_UP   = 1'b0,
      SERVO_POS_DOWN = 1'b1
   } servo_pos_t;
endpackage

interface ServoCtrl_IF;
   Servo_PKG::servo_pos_t pos;
   logic                  trigger;
   logic                  rdy;

   modport master (output pos, output trigger, input rdy);
   modport slave  (input pos, input trigger, output rdy);
endinterface

// File: rtl/pen_cmd_dispatcher.sv
// rtl/pen_cmd_dispatcher.sv - pen command FIFO and ServoCtrl issue/settle/retire sequencer
// Optional PEN_DISPATCH_SKIP_REDUNDANT_EN retires commands matching the confirmed position without a move.
module pen_cmd_dispatcher #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  cmd_valid,
   input  Servo_PKG::servo_pos_t cmd_pos,
   output logic                  cmd_rdy,
   ServoCtrl_IF.master           intf,
   output Servo_PKG::servo_pos_t pen_pos,
   output logic                  pen_pos_valid,
   output logic                  done,
   output logic                  busy
);
   import Servo_PKG::*;

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CNTW-1:0] FULL_CNT    = CNTW'(FIFO_DEPTH);
   localparam logic [CW-1:0]   SETTLE_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      SETTLE,
      RETIRE
   } state_t;

   state_t          state;
   state_t          next_state;
   servo_pos_t      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic [CW-1:0]   cnt;
   servo_pos_t      cur_pos;
   servo_pos_t      head;
   logic            trigger_q;
   logic            empty;
   logic            push;
   logic            pop;
   logic            cnt_load;

   assign empty   = (count == '0);
   assign cmd_rdy = (count != FULL_CNT);
   assign push    = cmd_valid && cmd_rdy;
   assign head    = mem[rd_ptr];

   assign intf.pos     = cur_pos;
   assign intf.trigger = trigger_q;
   assign done         = (state == RETIRE);
   assign busy         = !empty || (state != IDLE);

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      cnt_load   = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && intf.rdy) begin
               pop        = 1'b1;
               next_state = ISSUE;
`ifdef PEN_DISPATCH_SKIP_REDUNDANT_EN
               if (pen_pos_valid && (head == pen_pos)) begin
                  next_state = RETIRE;
               end
`endif
            end
         end
         ISSUE: begin
            // Only a low rdy seen after our own trigger counts as acceptance.
            if (trigger_q && !intf.rdy) begin
               next_state = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (intf.rdy) begin
               if (SETTLE_CYCLES == 0) begin
                  next_state = RETIRE;
               end else begin
                  next_state = SETTLE;
                  cnt_load   = 1'b1;
               end
            end
         end
         SETTLE: begin
            if (clk_en && (cnt == '0)) begin
               next_state = RETIRE;
            end
         end
         RETIRE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= cmd_pos;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         cnt           <= '0;
         cur_pos       <= SERVO_POS_UP;
         trigger_q     <= 1'b0;
         pen_pos       <= SERVO_POS_UP;
         pen_pos_valid <= 1'b0;
      end else begin
         state <= next_state;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            cur_pos <= head;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // Trigger rises one cycle into ISSUE so pos has settled before the servo sees it.
         trigger_q <= (state == ISSUE) && (next_state == ISSUE);
         if (cnt_load) begin
            cnt <= SETTLE_LOAD;
         end else if ((state == SETTLE) && clk_en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (state == RETIRE) begin
            pen_pos       <= cur_pos;
            pen_pos_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pen_cmd_dispatcher.sv
// tb/tb_pen_cmd_dispatcher.sv - directed self-checking bench for pen_cmd_dispatcher
module tb_pen_cmd_dispatcher;
   import Servo_PKG::*;

   localparam int SERVO_LOW = 10;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       clk_en;
   logic       cmd_valid;
   servo_pos_t cmd_pos;
   logic       cmd_rdy;
   servo_pos_t pen_pos;
   logic       pen_pos_valid;
   logic       done;
   logic       busy;

   logic       b_clk_en = 1'b0;
   logic       b_cmd_valid;
   servo_pos_t b_cmd_pos;
   logic       b_cmd_rdy;
   servo_pos_t b_pen_pos;
   logic       b_pen_pos_valid;
   logic       b_done;
   logic       b_busy;
   logic       b_rdy = 1'b1;

   ServoCtrl_IF sif ();
   ServoCtrl_IF sif_b ();

   pen_cmd_dispatcher #(.FIFO_DEPTH(4), .SETTLE_CYCLES(4)) u_dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .cmd_valid(cmd_valid), .cmd_pos(cmd_pos),
      .cmd_rdy(cmd_rdy), .intf(sif), .pen_pos(pen_pos), .pen_pos_valid(pen_pos_valid),
      .done(done), .busy(busy)
   );

   pen_cmd_dispatcher #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) u_dut_b (
      .clk(clk), .reset(reset), .clk_en(b_clk_en), .cmd_valid(b_cmd_valid), .cmd_pos(b_cmd_pos),
      .cmd_rdy(b_cmd_rdy), .intf(sif_b), .pen_pos(b_pen_pos), .pen_pos_valid(b_pen_pos_valid),
      .done(b_done), .busy(b_busy)
   );

   // Behavioural servo: accepts a trigger when ready, then stays busy SERVO_LOW cycles.
   logic srv_rdy = 1'b1;
   logic servo_stall = 1'b0;
   int   srv_cnt = 0;
   assign sif.rdy   = srv_rdy;
   assign sif_b.rdy = b_rdy;

   always @(posedge clk) begin
      if (servo_stall) begin
         srv_rdy <= 1'b0;
      end else if (srv_rdy && sif.trigger) begin
         srv_rdy <= 1'b0;
         srv_cnt <= SERVO_LOW - 1;
      end else if (!srv_rdy) begin
         if (srv_cnt == 0) srv_rdy <= 1'b1;
         else srv_cnt <= srv_cnt - 1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) b_clk_en = (cyc % 4 == 0);

   logic trig_q = 1'b0;
   logic rdy_q = 1'b1;
   logic done_q = 1'b0;
   int   trig_cnt = 0, trig_rise_cyc = 0, trig_fall_cyc = 0;
   int   rdy_rise_cyc = 0, rdy_fall_cyc = 0;
   int   done_cnt = 0, done_cyc = 0, done_prev_cyc = 0, done_wide = 0;
   servo_pos_t done_pos[$];

   always @(posedge clk) begin
      #1;
      if (sif.trigger && !trig_q) begin trig_cnt++; trig_rise_cyc = cyc; end
      if (!sif.trigger && trig_q) trig_fall_cyc = cyc;
      if (sif.rdy && !rdy_q) rdy_rise_cyc = cyc;
      if (!sif.rdy && rdy_q) rdy_fall_cyc = cyc;
      if (done) begin
         done_cnt++;
         done_prev_cyc = done_cyc;
         done_cyc = cyc;
         done_pos.push_back(sif.pos);
         if (done_q) done_wide++;
      end
      trig_q = sif.trigger;
      rdy_q  = sif.rdy;
      done_q = done;
   end

   int total = 0;
   int bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input servo_pos_t p);
      cmd_valid = 1'b1;
      cmd_pos   = p;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_cmd_rdy"}, cmd_rdy, 1);
      check_eq({pfx, "_trigger"}, sif.trigger, 0);
      check_eq({pfx, "_pos"}, sif.pos, SERVO_POS_UP);
      check_eq({pfx, "_pen_pos"}, pen_pos, SERVO_POS_UP);
      check_eq({pfx, "_pen_pos_valid"}, pen_pos_valid, 0);
      check_eq({pfx, "_done"}, done, 0);
      check_eq({pfx, "_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int push_cyc, d0, t0, r, k;
      servo_pos_t exp_seq[5];
      exp_seq = '{SERVO_POS_UP, SERVO_POS_DOWN, SERVO_POS_UP, SERVO_POS_DOWN, SERVO_POS_UP};
      reset = 1'b0; clk_en = 1'b1; cmd_valid = 1'b0; cmd_pos = SERVO_POS_UP;
      b_cmd_valid = 1'b0; b_cmd_pos = SERVO_POS_UP;
      repeat (2) @(negedge clk);
      check_reset_state("rst");
      check_eq("rst_b_busy", b_busy, 0);
      reset = 1'b1;
      @(negedge clk);

      // Single DOWN command, SETTLE_CYCLES=4, clk_en always high
      push(SERVO_POS_DOWN);
      push_cyc = cyc;
      for (k = 0; k < 100 && done_cnt < 1; k++) @(negedge clk);
      check_eq("t1_done_seen", done_cnt, 1);
      check_eq("t1_trig_rise", trig_rise_cyc - push_cyc, 2);
      check_eq("t1_trig_fall", trig_fall_cyc - rdy_fall_cyc, 1);
      check_eq("t1_done_lat", done_cyc - rdy_rise_cyc, 5);
      @(negedge clk);
      check_eq("t1_pen_pos", pen_pos, SERVO_POS_DOWN);
      check_eq("t1_pen_valid", pen_pos_valid, 1);

      // Fill FIFO while servo is held busy, then drain 5 commands in order
      d0 = done_cnt;
      done_pos.delete();
      servo_stall = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) push(exp_seq[i]);
      check_eq("t2_full_cmd_rdy", cmd_rdy, 0);
      check_eq("t2_full_busy", busy, 1);
      servo_stall = 1'b0;
      cmd_valid = 1'b1;
      cmd_pos = exp_seq[4];
      for (k = 0; k < 100 && !cmd_rdy; k++) @(negedge clk);
      check_eq("t2_space_freed", cmd_rdy, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (k = 0; k < 600 && done_cnt - d0 < 5; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      check_eq("t2_done_count", done_cnt - d0, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < done_pos.size()) check_eq($sformatf("t2_order%0d", i), done_pos[i], exp_seq[i]);
         else check_eq($sformatf("t2_order%0d_missing", i), 0, 1);
      end
      check_eq("t2_idle_busy", busy, 0);

      // DOWN then DOWN from a confirmed UP
      d0 = done_cnt;
      t0 = trig_cnt;
      push(SERVO_POS_DOWN);
      push(SERVO_POS_DOWN);
      for (k = 0; k < 200 && done_cnt - d0 < 2; k++) @(negedge clk);
      check_eq("t3_done_count", done_cnt - d0, 2);
`ifdef PEN_DISPATCH_SKIP_REDUNDANT_EN
      check_eq("t3_trig_count", trig_cnt - t0, 1);
      check_eq("t3_skip_done_gap", done_cyc - done_prev_cyc, 2);
`else
      check_eq("t3_trig_count", trig_cnt - t0, 2);
`endif

      // Second instance: SETTLE_CYCLES=3 with clk_en every 4th cycle
      b_cmd_valid = 1'b1;
      b_cmd_pos = SERVO_POS_DOWN;
      @(negedge clk);
      b_cmd_valid = 1'b0;
      for (k = 0; k < 50 && !sif_b.trigger; k++) @(negedge clk);
      check_eq("t4_trigger_seen", sif_b.trigger, 1);
      b_rdy = 1'b0;
      repeat (3) @(negedge clk);
      b_rdy = 1'b1;
      r = cyc;
      for (k = 0; k < 60 && !b_done; k++) @(negedge clk);
      check_eq("t4_done_seen", b_done, 1);
      check_eq("t4_settle_window", ((cyc - r) >= 9) && ((cyc - r) <= 15), 1);
      @(negedge clk);
      check_eq("t4_pen_pos", b_pen_pos, SERVO_POS_DOWN);

      // Reset while in WAIT_DONE with two commands queued
      push(SERVO_POS_UP);
      for (k = 0; k < 50 && !(!sif.trigger && !sif.rdy); k++) @(negedge clk);
      check_eq("t5_in_wait_done", !sif.trigger && !sif.rdy, 1);
      push(SERVO_POS_UP);
      push(SERVO_POS_DOWN);
      check_eq("t5_busy_before", busy, 1);
      reset = 1'b0;
      @(negedge clk);
      check_reset_state("t5_rst");
      @(negedge clk);
      reset = 1'b1;
      t0 = trig_cnt;
      d0 = done_cnt;
      push(SERVO_POS_DOWN);
      for (k = 0; k < 50 && !sif.rdy; k++) @(negedge clk);
      check_eq("t5_rdy_back", sif.rdy, 1);
      check_eq("t5_no_early_trig", trig_cnt - t0, 0);
      for (k = 0; k < 50 && trig_cnt == t0; k++) @(negedge clk);
      check_eq("t5_trig_after_rdy", trig_rise_cyc > rdy_rise_cyc, 1);
      for (k = 0; k < 100 && done_cnt == d0; k++) @(negedge clk);
      check_eq("t5_done_count", done_cnt - d0, 1);
      @(negedge clk);
      check_eq("t5_pen_pos", pen_pos, SERVO_POS_DOWN);

      check_eq("done_single_cycle", done_wide, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pen_cmd_dispatcher.md
# pen_cmd_dispatcher

Buffers pen up/down commands from the instruction processor and issues them to `ServoCtrl`, one at a time, over the `ServoCtrl_IF` trigger/rdy handshake. Sits directly upstream of `ServoCtrl`: accepts commands through a valid/ready port, and holds a small FIFO. After each servo move it waits a configurable settle time, then retires the command with a one-cycle done pulse. It also tracks the confirmed pen position.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `SETTLE_CYCLES`, 1000: enabled (`clk_en`) cycles to wait after servo reports done; 0 = no settle.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `clk_en`  in  1  tick enable; gates the settle counter only.
- `cmd_valid`  in  1  command present.
- `cmd_pos`  in  `Servo_PKG` pos type  requested pen position (`SERVO_POS_UP` / `SERVO_POS_DOWN`).
- `cmd_rdy`  out  1  FIFO not full.
- `intf`  `ServoCtrl_IF.master`  drives `pos`, `trigger`; samples `rdy`.
- `pen_pos`  out  pos type  last confirmed position.
- `pen_pos_valid`  out  1  `pen_pos` is meaningful.
- `done`  out  1  one-cycle pulse per retired command.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- A command is pushed on a rising edge with `cmd_valid && cmd_rdy`.
- `cmd_rdy = !full`, with no same-cycle bypass. A pop frees space on the next cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty and `intf.rdy==1`, pop the head into `cur_pos`, then go to ISSUE. Under the macro, this may instead go to RETIRE (see Configuration).
  - ISSUE: `trigger=1`, `pos=cur_pos`. Hold until `intf.rdy==0` is sampled, then deassert `trigger` and go to WAIT_DONE.
  - WAIT_DONE: wait for `intf.rdy==1`.
    - If `SETTLE_CYCLES==0`, go to RETIRE.
    - Otherwise load the counter with `SETTLE_CYCLES-1` and go to SETTLE.
  - SETTLE: on cycles with `clk_en`, decrement. The cycle the count is 0 with `clk_en` high, go to RETIRE.
  - RETIRE: assert `done` for one cycle, set `pen_pos=cur_pos` and `pen_pos_valid=1`, then go to IDLE.
- `intf.pos` holds `cur_pos` continuously outside reset. It is stable while `trigger` is high.
- The counter is `$clog2(SETTLE_CYCLES+1)` bits wide and never wraps.
- Reset values:
  - `cmd_rdy=1`, `trigger=0`, `intf.pos=SERVO_POS_UP`.
  - `pen_pos=SERVO_POS_UP`, `pen_pos_valid=0`.
  - `done=0`, `busy=0`; FIFO empty; FSM in IDLE.
- Reset mid-operation:
  - Pending commands are discarded and `trigger` drops on the next edge.
  - A servo move already in flight completes on its own.
  - The next command is not issued until `intf.rdy` returns high, per the IDLE rule.

## Timing
- Push to visibility: a command pushed at edge N can be popped at edge N+1 at the earliest.
- With the servo ready, `trigger` rises at N+2.
- `trigger` is registered. It stays high at least one cycle and falls on the edge after `rdy==0` is sampled.
- Retire latency: `done` rises one cycle after the last SETTLE cycle, or one cycle after `rdy` rises when `SETTLE_CYCLES==0`.
- Back-to-back commands: the next pop occurs in the IDLE cycle immediately after RETIRE. There are no other idle bubbles.
- Simultaneous push and pop on a full FIFO: the push is refused because `cmd_rdy=0`; the pop proceeds.
- The FIFO pointers use `$clog2(FIFO_DEPTH)` bits with natural wrap. A separate count tracks full/empty.

## Configuration
- Macro: `PEN_DISPATCH_SKIP_REDUNDANT_EN`.
- Defined: in IDLE, if `pen_pos_valid` and the head equals `pen_pos`, pop and go straight to RETIRE. No trigger is issued and there is no settle. `done` still pulses one cycle after the pop.
- Undefined: every command runs the full ISSUE/WAIT_DONE/SETTLE sequence, regardless of `pen_pos`.

## Test plan
- Reset low 2 cycles, then push DOWN with a behavioural ServoCtrl model (rdy low 10 cycles), `SETTLE_CYCLES=4`, `clk_en=1`:
  - `trigger` is high at cycle +2 and falls after `rdy` drops.
  - `done` pulses 5 cycles after `rdy` rises.
  - `pen_pos=DOWN`, `pen_pos_valid=1`.
- Push 5 commands back-to-back at `FIFO_DEPTH=4` while the servo is busy: `cmd_rdy` is 0 after the 4th accepted push, and all 5 retire in order UP/DOWN/UP/DOWN/UP with exactly 5 `done` pulses.
- Macro defined, push DOWN then DOWN:
  - The second command produces no `trigger`.
  - Its `done` follows its pop by 1 cycle.
- Macro undefined, push DOWN then DOWN: 2 triggers are issued.
- `clk_en` high every 4th cycle, `SETTLE_CYCLES=3`: `done` comes 12±3 clk cycles after `rdy` rises.
- Assert reset during WAIT_DONE with 2 commands queued:
  - Outputs return to their reset values and the FIFO is empty.
  - A new push waits for `rdy==1` before `trigger` rises.
